demux_1xn_stream: RTL and testbench

- Parametrised 1-to-N stream demultiplexer; the registered, handshaked successor to the team's combinational 1x4 demux.
- Routes input beats (data plus last) to one of N output channels selected by in_sel, through a single output register stage with valid/ready flow control.
- Packet lock: the destination is sampled on the first beat of a packet and held until the beat carrying in_last.
- Sits between a single producer and N consumer channels, e.g. for splitting a byte stream across per-lane FIFOs.

---
 rtl/demux_1xn_stream_pkg.sv | 20 ++
 rtl/demux_1xn_stream_out_reg.sv | 39 +++
 rtl/demux_1xn_stream.sv | 137 +++++++++++++
 tb/tb_demux_1xn_stream.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/demux_1xn_stream_pkg.sv
// Shared types and helpers for the 1-to-N stream demultiplexer.
// Holds the lock FSM state type, the selector-width helper and the drop counter width.
package demux_pkg;

    localparam int DROP_CNT_W = 16;

    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } state_t;

    // Selector width that never collapses to zero bits.
    function automatic int clog2_min1(input int n);
        int r;
        r = 1;
        while ((1 << r) < n) r = r + 1;
        return r;
    endfunction

endpackage

// File: rtl/demux_1xn_stream_out_reg.sv
// Single-entry holding register: stores one beat (data, last, destination) with a valid flag.
// Latency: a load appears on hold_* the cycle after the load edge.
// Backpressure: the entry stays put until take; load wins over take in the same cycle.
module demux_out_reg
    import demux_pkg::*;
#(
    parameter int W  = 8,
    parameter int SW = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [W-1:0]  load_data,
    input  logic          load_last,
    input  logic [SW-1:0] load_dst,
    input  logic          take,
    output logic          hold_vld,
    output logic [W-1:0]  hold_data,
    output logic          hold_last,
    output logic [SW-1:0] hold_dst
);

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_vld  <= 1'b0;
            hold_data <= '0;
            hold_last <= 1'b0;
            hold_dst  <= '0;
        end else if (load) begin
            hold_vld  <= 1'b1;
            hold_data <= load_data;
            hold_last <= load_last;
            hold_dst  <= load_dst;
        end else if (take) begin
            hold_vld  <= 1'b0;
        end
    end

endmodule

// File: rtl/demux_1xn_stream.sv
// Registered 1-to-N stream demux with per-packet destination lock; optional drop counter via DEMUX_DROP_CNT_EN.
// Latency: one cycle from accept to out_valid; full throughput when the selected consumer is ready.
// Backpressure: in_ready follows only the ready of the channel holding the pending beat; out-of-range beats are accepted and dropped.
module demux_1xn_stream
    import demux_pkg::*;
#(
    parameter  int N  = 4,
    parameter  int W  = 8,
    localparam int SW = clog2_min1(N)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [W-1:0]    in_data,
    input  logic [SW-1:0]   in_sel,
    input  logic            in_last,
    input  logic            in_valid,
    output logic            in_ready,
    output logic [N*W-1:0]  out_data,
    output logic [N-1:0]    out_last,
    output logic [N-1:0]    out_valid,
    input  logic [N-1:0]    out_ready,
    output logic            sel_err,
    output logic            busy
`ifdef DEMUX_DROP_CNT_EN
    , output logic [DROP_CNT_W-1:0] drop_cnt
`endif
);

    state_t        state;
    state_t        state_nxt;
    logic [SW-1:0] lock_sel;
    logic [SW-1:0] dst;
    logic          dst_ok;
    logic          sel_rdy;
    logic          accept;
    logic          take;
    logic          load;

    logic          hold_vld;
    logic [W-1:0]  hold_data;
    logic          hold_last;
    logic [SW-1:0] hold_dst;

    // Ready of whichever channel owns the pending beat; other channels never stall us.
    always_comb begin
        sel_rdy = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (hold_dst == SW'(k)) sel_rdy = out_ready[k];
        end
    end

    assign in_ready = !hold_vld || sel_rdy;
    assign accept   = in_valid && in_ready;
    assign take     = hold_vld && sel_rdy;
    assign dst      = (state == LOCK) ? lock_sel : in_sel;

    always_comb begin
        dst_ok = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (dst == SW'(k)) dst_ok = 1'b1;
        end
    end

    assign load = accept && dst_ok;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (accept) begin
            case (state)
                IDLE:    if (!in_last) state_nxt = LOCK;
                LOCK:    if (in_last)  state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        busy = (state == LOCK);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lock_sel <= '0;
            sel_err  <= 1'b0;
        end else begin
            if (accept && (state == IDLE) && !in_last) lock_sel <= in_sel;
            sel_err <= accept && !dst_ok;
        end
    end

`ifdef DEMUX_DROP_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            drop_cnt <= '0;
        end else if (accept && !dst_ok && (drop_cnt != {DROP_CNT_W{1'b1}})) begin
            drop_cnt <= drop_cnt + DROP_CNT_W'(1);
        end
    end
`endif

    demux_out_reg #(
        .W  (W),
        .SW (SW)
    ) u_out_reg (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .load_data (in_data),
        .load_last (in_last),
        .load_dst  (dst),
        .take      (take),
        .hold_vld  (hold_vld),
        .hold_data (hold_data),
        .hold_last (hold_last),
        .hold_dst  (hold_dst)
    );

    // Non-selected slices read as zero so each consumer only ever sees its own beats.
    always_comb begin
        out_valid = '0;
        out_data  = '0;
        out_last  = '0;
        for (int k = 0; k < N; k++) begin
            if (hold_vld && (hold_dst == SW'(k))) begin
                out_valid[k]         = 1'b1;
                out_data[k*W +: W]   = hold_data;
                out_last[k]          = hold_last;
            end
        end
    end

endmodule

// File: tb/tb_demux_1xn_stream.sv
// Bench for demux_1xn_stream: one N=4 and one N=3 instance, directed scenarios then random traffic.
// A beat-level reference model is compared against every output on every falling edge.
module tb_demux_1xn_stream;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_i  [2];
    logic [7:0] dat_i  [2];
    logic [1:0] sel_i  [2];
    logic       lst_i  [2];
    logic       v_i    [2];
    logic [3:0] ordy_i [2];

    logic        ir0, err0, busy0;
    logic [31:0] od0;
    logic [3:0]  ol0, ov0;
    logic        ir1, err1, busy1;
    logic [23:0] od1;
    logic [2:0]  ol1, ov1;
`ifdef DEMUX_DROP_CNT_EN
    logic [15:0] dc0, dc1;
`endif

    demux_1xn_stream #(.N(4), .W(8)) u_dut4 (
`ifdef DEMUX_DROP_CNT_EN
        .drop_cnt  (dc0),
`endif
        .clk       (clk),
        .rst       (rst_i[0]),
        .in_data   (dat_i[0]),
        .in_sel    (sel_i[0]),
        .in_last   (lst_i[0]),
        .in_valid  (v_i[0]),
        .in_ready  (ir0),
        .out_data  (od0),
        .out_last  (ol0),
        .out_valid (ov0),
        .out_ready (ordy_i[0]),
        .sel_err   (err0),
        .busy      (busy0)
    );

    demux_1xn_stream #(.N(3), .W(8)) u_dut3 (
`ifdef DEMUX_DROP_CNT_EN
        .drop_cnt  (dc1),
`endif
        .clk       (clk),
        .rst       (rst_i[1]),
        .in_data   (dat_i[1]),
        .in_sel    (sel_i[1]),
        .in_last   (lst_i[1]),
        .in_valid  (v_i[1]),
        .in_ready  (ir1),
        .out_data  (od1),
        .out_last  (ol1),
        .out_valid (ov1),
        .out_ready (ordy_i[1][2:0]),
        .sel_err   (err1),
        .busy      (busy1)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [3:0]  get_ov(input int i); return (i == 0) ? ov0 : {1'b0, ov1}; endfunction
    function automatic logic [3:0]  get_ol(input int i); return (i == 0) ? ol0 : {1'b0, ol1}; endfunction
    function automatic logic [31:0] get_od(input int i); return (i == 0) ? od0 : {8'h00, od1}; endfunction
    function automatic logic        get_ir(input int i); return (i == 0) ? ir0 : ir1; endfunction
    function automatic logic        get_er(input int i); return (i == 0) ? err0 : err1; endfunction
    function automatic logic        get_bz(input int i); return (i == 0) ? busy0 : busy1; endfunction
    function automatic int          nch(input int i);    return (i == 0) ? 4 : 3; endfunction

    // Reference model: the pending beat (if any), packet lock and drop bookkeeping.
    logic       m_known [2] = '{1'b0, 1'b0};
    logic       m_pv    [2];
    int         m_pch   [2];
    logic [7:0] m_pdat  [2];
    logic       m_plst  [2];
    logic       m_inpkt [2];
    int         m_lch   [2];
    logic       m_err   [2];
    logic [15:0] m_cnt  [2];

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            logic [3:0]  ev;
            logic [31:0] ed;
            logic        er;
            logic        acc;
            int          ch;
            if (m_known[i]) begin
                ev = m_pv[i] ? 4'(1 << m_pch[i]) : 4'h0;
                ed = m_pv[i] ? (32'(m_pdat[i]) << (8 * m_pch[i])) : 32'h0;
                er = !m_pv[i] || ordy_i[i][m_pch[i]];
                chk($sformatf("u%0d out_valid", i), 32'(get_ov(i)), 32'(ev));
                chk($sformatf("u%0d out_data", i),  get_od(i), ed);
                chk($sformatf("u%0d out_last", i),  32'(get_ol(i)), 32'(m_plst[i] ? ev : 4'h0));
                chk($sformatf("u%0d in_ready", i),  32'(get_ir(i)), 32'(er));
                chk($sformatf("u%0d sel_err", i),   32'(get_er(i)), 32'(m_err[i]));
                chk($sformatf("u%0d busy", i),      32'(get_bz(i)), 32'(m_inpkt[i]));
`ifdef DEMUX_DROP_CNT_EN
                chk($sformatf("u%0d drop_cnt", i),  32'((i == 0) ? dc0 : dc1), 32'(m_cnt[i]));
`endif
            end
            // Advance the model by the upcoming rising edge.
            if (rst_i[i]) begin
                m_known[i] = 1'b1;
                m_pv[i] = 1'b0; m_pch[i] = 0; m_pdat[i] = 8'h0; m_plst[i] = 1'b0;
                m_inpkt[i] = 1'b0; m_lch[i] = 0; m_err[i] = 1'b0; m_cnt[i] = 16'h0;
            end else if (m_known[i]) begin
                acc = v_i[i] && (!m_pv[i] || ordy_i[i][m_pch[i]]);
                ch  = m_inpkt[i] ? m_lch[i] : int'(sel_i[i]);
                if (m_pv[i] && ordy_i[i][m_pch[i]]) m_pv[i] = 1'b0;
                m_err[i] = acc && (ch >= nch(i));
                if (acc && (ch < nch(i))) begin
                    m_pv[i] = 1'b1; m_pch[i] = ch; m_pdat[i] = dat_i[i]; m_plst[i] = lst_i[i];
                end
                if (m_err[i] && (m_cnt[i] != 16'hFFFF)) m_cnt[i] = m_cnt[i] + 16'h1;
                if (acc) begin
                    if (m_inpkt[i] && lst_i[i]) m_inpkt[i] = 1'b0;
                    else if (!m_inpkt[i] && !lst_i[i]) begin
                        m_inpkt[i] = 1'b1;
                        m_lch[i]   = int'(sel_i[i]);
                    end
                end
            end
        end
    end

    task automatic drive(input int i, input logic v, input logic [1:0] s, input logic [7:0] d, input logic l);
        v_i[i] = v; sel_i[i] = s; dat_i[i] = d; lst_i[i] = l;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [3:0]  single_ov [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    logic [31:0] single_od [4] = '{32'h000000A1, 32'h0000A200, 32'h00A30000, 32'hA4000000};
    logic [7:0]  single_d  [4] = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};

    initial begin
        for (int i = 0; i < 2; i++) begin
            rst_i[i] = 1'b1; ordy_i[i] = 4'hF;
            drive(i, 1'b1, 2'd0, 8'h00, 1'b0);
        end
        tick(); tick();
        chk("reset out_valid", 32'(get_ov(0)), 32'h0);
        chk("reset out_data",  get_od(0), 32'h0);
        chk("reset sel_err",   32'(get_er(0)), 32'h0);
        chk("reset busy",      32'(get_bz(0)), 32'h0);
        chk("reset out_valid n3", 32'(get_ov(1)), 32'h0);
        for (int i = 0; i < 2; i++) begin
            rst_i[i] = 1'b0;
            drive(i, 1'b0, 2'd0, 8'h00, 1'b0);
        end
        #1;
        chk("idle in_ready", 32'(get_ir(0)), 32'h1);

        // Single-beat packets to each channel, back to back.
        for (int k = 0; k < 4; k++) begin
            drive(0, 1'b1, 2'(k), single_d[k], 1'b1);
            tick();
            chk("single out_valid", 32'(get_ov(0)), 32'(single_ov[k]));
            chk("single out_data",  get_od(0), single_od[k]);
        end
        drive(0, 1'b0, 2'd0, 8'h00, 1'b0);
        tick();
        chk("single drain", 32'(get_ov(0)), 32'h0);

        // Packet lock: in_sel on beats 2 and 3 must be ignored.
        drive(0, 1'b1, 2'd2, 8'h10, 1'b0); tick();
        chk("lock b1 valid", 32'(get_ov(0)), 32'h4);
        chk("lock b1 data",  get_od(0), 32'h00100000);
        chk("lock b1 busy",  32'(get_bz(0)), 32'h1);
        drive(0, 1'b1, 2'd0, 8'h11, 1'b0); tick();
        chk("lock b2 valid", 32'(get_ov(0)), 32'h4);
        chk("lock b2 data",  get_od(0), 32'h00110000);
        chk("lock b2 busy",  32'(get_bz(0)), 32'h1);
        drive(0, 1'b1, 2'd3, 8'h12, 1'b1); tick();
        chk("lock b3 valid", 32'(get_ov(0)), 32'h4);
        chk("lock b3 data",  get_od(0), 32'h00120000);
        chk("lock b3 last",  32'(get_ol(0)), 32'h4);
        chk("lock b3 busy",  32'(get_bz(0)), 32'h0);
        drive(0, 1'b0, 2'd0, 8'h00, 1'b0); tick();

        // Back-pressure on channel 1 with a beat for channel 3 queued behind it.
        ordy_i[0] = 4'b1101;
        drive(0, 1'b1, 2'd1, 8'h55, 1'b1); tick();
        chk("bp load valid", 32'(get_ov(0)), 32'h2);
        chk("bp load data",  get_od(0), 32'h00005500);
        drive(0, 1'b1, 2'd3, 8'h66, 1'b1); #1;
        chk("bp in_ready", 32'(get_ir(0)), 32'h0);
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("bp hold valid", 32'(get_ov(0)), 32'h2);
            chk("bp hold data",  get_od(0), 32'h00005500);
            chk("bp hold in_ready", 32'(get_ir(0)), 32'h0);
        end
        ordy_i[0] = 4'hF; #1;
        chk("bp release in_ready", 32'(get_ir(0)), 32'h1);
        tick();
        chk("bp next valid", 32'(get_ov(0)), 32'h8);
        chk("bp next data",  get_od(0), 32'h66000000);
        drive(0, 1'b0, 2'd0, 8'h00, 1'b0); tick();
        chk("bp drain", 32'(get_ov(0)), 32'h0);

        // Reset in the middle of a packet drops the lock.
        drive(0, 1'b1, 2'd1, 8'h77, 1'b0); tick();
        chk("mid b1 busy",  32'(get_bz(0)), 32'h1);
        chk("mid b1 valid", 32'(get_ov(0)), 32'h2);
        rst_i[0] = 1'b1;
        drive(0, 1'b0, 2'd0, 8'h00, 1'b0); tick();
        chk("mid rst busy",  32'(get_bz(0)), 32'h0);
        chk("mid rst valid", 32'(get_ov(0)), 32'h0);
        rst_i[0] = 1'b0;
        drive(0, 1'b1, 2'd0, 8'h88, 1'b1); tick();
        chk("mid next valid", 32'(get_ov(0)), 32'h1);
        chk("mid next data",  get_od(0), 32'h00000088);
        drive(0, 1'b0, 2'd0, 8'h00, 1'b0); tick();

        // Out-of-range destination on the N=3 instance: both beats dropped.
        drive(1, 1'b1, 2'd3, 8'h31, 1'b0); tick();
        chk("oor b1 valid", 32'(get_ov(1)), 32'h0);
        chk("oor b1 sel_err", 32'(get_er(1)), 32'h1);
        chk("oor b1 busy", 32'(get_bz(1)), 32'h1);
        drive(1, 1'b1, 2'd0, 8'h32, 1'b1); tick();
        chk("oor b2 valid", 32'(get_ov(1)), 32'h0);
        chk("oor b2 sel_err", 32'(get_er(1)), 32'h1);
        chk("oor b2 busy", 32'(get_bz(1)), 32'h0);
        drive(1, 1'b0, 2'd0, 8'h00, 1'b0); tick();
        chk("oor sel_err clears", 32'(get_er(1)), 32'h0);
`ifdef DEMUX_DROP_CNT_EN
        chk("oor drop_cnt", 32'(dc1), 32'h2);
`endif

        // Random traffic, one instance at a time, with occasional resets.
        for (int i = 0; i < 2; i++) begin
            for (int c = 0; c < 3000; c++) begin
                rst_i[i]  = ($urandom_range(0, 199) == 0);
                drive(i, ($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
                      8'($urandom), ($urandom_range(0, 2) == 0));
                ordy_i[i] = 4'($urandom) | (($urandom_range(0, 1) == 1) ? 4'hF : 4'h0);
                tick();
            end
            rst_i[i] = 1'b0;
            ordy_i[i] = 4'hF;
            drive(i, 1'b0, 2'd0, 8'h00, 1'b0);
            tick(); tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
